// File: rtl/toggle_seq_pkg.sv
// Shared types and helpers for the toggle sequence generator.
// State encoding, default LFSR feedback mask and the Galois LFSR step function.
package toggle_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } tsg_state_e;

   localparam int unsigned TSG_MAX_W    = 64;
   localparam logic [15:0] TSG_TAPS_DEF = 16'hB400;

   // Width-agnostic Galois step: callers zero-extend to TSG_MAX_W and truncate back.
   function automatic logic [TSG_MAX_W-1:0] lfsr_next(input logic [TSG_MAX_W-1:0] x,
                                                      input logic [TSG_MAX_W-1:0] taps);
      return (x >> 1) ^ (x[0] ? taps : '0);
   endfunction

endpackage

// File: rtl/toggle_seq_lfsr.sv
// Galois LFSR register with load/advance controls and zero-seed fixup.
// Exposes the fixed-up seed and the next value combinationally for same-edge use.
module toggle_seq_lfsr
   import toggle_seq_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TSG_TAPS_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic             adv_i,
   output logic [WIDTH-1:0] seed_fix_c,
   output logic [WIDTH-1:0] lfsr_nxt_c
);

   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_d;

   // An all-zero state would lock the LFSR, so a zero seed becomes 1.
   assign seed_fix_c = (seed_i == '0) ? WIDTH'(1) : seed_i;
   assign lfsr_nxt_c = WIDTH'(lfsr_next(TSG_MAX_W'(lfsr_q), TSG_MAX_W'(TAPS)));

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = seed_fix_c;
      end else if (adv_i) begin
         lfsr_d = lfsr_nxt_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= WIDTH'(1);
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/toggle_seq_gen.sv
// Burst stimulus generator: lead beat, then LFSR-driven RUN beats with a toggling flag.
// Optional TOGGLE_SEQ_GEN_ERR_INJ_EN adds err_inj_i to corrupt selected RUN beats.
module toggle_seq_gen
   import toggle_seq_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter int unsigned      CNT_W = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TSG_TAPS_DEF)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [CNT_W-1:0] start_len,
   input  logic [WIDTH-1:0] start_seed,
   input  logic             abort_i,
`ifdef TOGGLE_SEQ_GEN_ERR_INJ_EN
   input  logic             err_inj_i,
`endif
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             c_o,
   output logic             d_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             done_o
);

   tsg_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             c_q, c_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic             lfsr_load;
   logic             lfsr_adv;
   logic             run_beat;
   logic [WIDTH-1:0] seed_fix;
   logic [WIDTH-1:0] lfsr_nxt;

   toggle_seq_lfsr #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_lfsr (
      .clk        (clock),
      .rst_n      (reset_n),
      .load_i     (lfsr_load),
      .seed_i     (start_seed),
      .adv_i      (lfsr_adv),
      .seed_fix_c (seed_fix),
      .lfsr_nxt_c (lfsr_nxt)
   );

   // Next state and next registered outputs; cnt_q counts RUN beats still to emit.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = '0;
      b_d       = '0;
      c_d       = 1'b0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      run_beat  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_valid && ready_q) begin
               state_d   = LEAD;
               cnt_d     = start_len;
               lfsr_load = 1'b1;
               a_d       = seed_fix;
               b_d       = seed_fix;
               valid_d   = 1'b1;
            end
         end
         LEAD, RUN: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d  = RUN;
               run_beat = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (run_beat) begin
         lfsr_adv = 1'b1;
         cnt_d    = cnt_q - CNT_W'(1);
         a_d      = lfsr_nxt;
         b_d      = lfsr_nxt;
         c_d      = ~c_q;
         valid_d  = 1'b1;
`ifdef TOGGLE_SEQ_GEN_ERR_INJ_EN
         if (err_inj_i) begin
            b_d = lfsr_nxt ^ WIDTH'(1);
            c_d = c_q;
         end
`endif
      end

      busy_d  = (state_d == LEAD) || (state_d == RUN);
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign start_ready = ready_q;
   assign a_o         = a_q;
   assign b_o         = b_q;
   assign c_o         = c_q;
   assign d_o         = 1'b0;
   assign valid_o     = valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
